// File: rtl/fifo_pkg.sv
// Shared definitions for the SDRAM-path FIFOs: clog2 helper, depth
// derivation and the parameter range limits that every FIFO checks at
// elaboration time.
package fifo_pkg;

    // Parameter range limits shared by the SDRAM-path FIFOs
    localparam int FIFO_MIN_DATA_WIDTH = 1;
    localparam int FIFO_MAX_DATA_WIDTH = 1024;
    localparam int FIFO_MIN_ADDR_WIDTH = 1;
    localparam int FIFO_MAX_ADDR_WIDTH = 16;

    // Default geometry; depth is always a power of two of the address width
    localparam int FIFO_DEFAULT_ADDR_WIDTH = 4;
    localparam int FIFO_DEFAULT_DEPTH      = 32'sd1 << FIFO_DEFAULT_ADDR_WIDTH;

    // Smallest r such that 2**r >= value
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Number of entries addressed by an address of the given width
    function automatic int fifo_depth(input int addr_width);
        return 32'sd1 << addr_width;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage for sync_fifo. One synchronous write port.
// Read port is asynchronous when SYNC_FIFO_FWFT_EN is defined and a
// registered (clearable, hold-until-next-read) port otherwise.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Storage write; contents are intentionally not cleared by clr
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is shown combinationally; pops only move the address
    assign rd_data = mem_r[rd_addr];

    logic unused_ok_s;
    assign unused_ok_s = &{1'b0, clr, rd_en};
`else
    logic [DATA_WIDTH-1:0] rd_data_r;

    // Registered read port: loads on a pop, holds between pops, clears on clr
    always_ff @(posedge clk) begin
        if (clr) begin
            rd_data_r <= {DATA_WIDTH{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_data = rd_data_r;
`endif

endmodule

// File: rtl/sync_fifo.sv
// Single-clock power-of-two FIFO with occupancy count, almost thresholds,
// sticky overflow/underflow and simultaneous read/write at full.
// Optional first-word-fall-through mode: define SYNC_FIFO_FWFT_EN.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = FIFO_DEFAULT_ADDR_WIDTH,
    parameter int AFULL_THRESH  = fifo_depth(ADDR_WIDTH) - 2,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  wr_req,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_req,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH:0]   use_num,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    // Elaboration-time parameter range checks
    if (DATA_WIDTH < FIFO_MIN_DATA_WIDTH || DATA_WIDTH > FIFO_MAX_DATA_WIDTH) begin : g_bad_data_width
        $fatal(1, "sync_fifo: DATA_WIDTH out of range");
    end
    if (ADDR_WIDTH < FIFO_MIN_ADDR_WIDTH || ADDR_WIDTH > FIFO_MAX_ADDR_WIDTH) begin : g_bad_addr_width
        $fatal(1, "sync_fifo: ADDR_WIDTH out of range");
    end
    if (clog2(DEPTH) != ADDR_WIDTH) begin : g_bad_depth
        $fatal(1, "sync_fifo: DEPTH is not 2**ADDR_WIDTH");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $fatal(1, "sync_fifo: AFULL_THRESH must be in 1..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
        $fatal(1, "sync_fifo: AEMPTY_THRESH must be in 0..DEPTH-1");
    end

    localparam logic [ADDR_WIDTH:0]   CNT_ZERO   = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_FULL   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   AFULL_CMP  = AFULL_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   AEMPTY_CMP = AEMPTY_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [ADDR_WIDTH:0]   use_num_r;
    logic [ADDR_WIDTH:0]   use_num_nxt_s;
    logic                  overflow_r;
    logic                  underflow_r;
    logic                  rd_acc_s;
    logic                  wr_acc_s;
    logic                  empty_s;
    logic                  full_s;

    // Status decodes of the registered count; glitch-free relative to clk
    assign empty_s      = (use_num_r == CNT_ZERO);
    assign full_s       = (use_num_r == CNT_FULL);
    assign empty        = empty_s;
    assign full         = full_s;
    assign almost_full  = (use_num_r >= AFULL_CMP);
    assign almost_empty = (use_num_r <= AEMPTY_CMP);
    assign use_num      = use_num_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

    // Request acceptance and next occupancy; a pop at full frees a slot for the push
    always_comb begin
        rd_acc_s      = 1'b0;
        wr_acc_s      = 1'b0;
        use_num_nxt_s = use_num_r;
        if (clr) begin
            rd_acc_s = 1'b0;
            wr_acc_s = 1'b0;
        end else begin
            rd_acc_s = rd_req & ~empty_s;
            wr_acc_s = wr_req & (~full_s | rd_acc_s);
        end
        case ({wr_acc_s, rd_acc_s})
            2'b10:   use_num_nxt_s = use_num_r + CNT_ONE;
            2'b01:   use_num_nxt_s = use_num_r - CNT_ONE;
            2'b11:   use_num_nxt_s = use_num_r;
            2'b00:   use_num_nxt_s = use_num_r;
            default: use_num_nxt_s = use_num_r;
        endcase
    end

    // Pointers, occupancy and sticky error flags
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr_r    <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r    <= {ADDR_WIDTH{1'b0}};
            use_num_r   <= CNT_ZERO;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            use_num_r <= use_num_nxt_s;
            if (wr_req & ~wr_acc_s) begin
                overflow_r <= 1'b1;
            end
            if (rd_req & empty_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is valid whenever anything is stored
    assign rd_valid = ~empty_s;
`else
    logic rd_valid_r;

    // rd_valid marks the single cycle after each accepted pop
    always_ff @(posedge clk) begin
        if (clr) begin
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_acc_s;
        end
    end

    assign rd_valid = rd_valid_r;
`endif

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .clr     (clr),
        .wr_en   (wr_acc_s),
        .wr_addr (wr_ptr_r),
        .wr_data (wr_data),
        .rd_en   (rd_acc_s),
        .rd_addr (rd_ptr_r),
        .rd_data (rd_data)
    );

endmodule
